iom_mem_tester: RTL and testbench
=================================

// Module: iom_mem_tester
// PURPOSE
//  MicroBlaze-MCS-style IO bus initiator: drives the same strobe/address/data/ready bus the
//  SDRAM IO wrapper answers. Built-in memory test: writes a pattern over a word range, reads
//  it back, compares, and reports pass/fail, error count and first failing address.
//  Sits beside the uBlaze to exercise SDRAM at bring-up without firmware.
// PARAMETERS
//  BASE_ADDR   25'h0000000   byte address of first word; bits [1:0] ignored
//  NUM_WORDS   24'd8388608   words tested, 1..2^23; 0 treated as 1
//  SEED        32'hA5A55A5A  pattern seed
//  TIMEOUT     16'd1024      io_clk cycles allowed from strobe to io_ready
// PORTS
//  io_clk          in   1   clock
//  io_rst          in   1   synchronous reset, active-high
//  start           in   1   1-cycle pulse: begin test; ignored while busy
//  busy            out  1   test in progress
//  done            out  1   high from test end until next start/reset
//  pass            out  1   valid when done: 1 = no errors, no timeout
//  timeout         out  1   valid when done: test aborted on missing io_ready
//  err_count       out  16  mismatching reads, saturates at 16'hFFFF
//  first_err_addr  out  25  byte address of first mismatch (0 if none)
//  io_addr_strobe  out  1   1-cycle request pulse
//  io_read_strobe  out  1   with addr strobe: read
//  io_write_strobe out  1   with addr strobe: write
//  io_address      out  25  byte address, held stable until io_ready
//  io_byte_enable  out  4   always 4'hF
//  io_write_data   out  32  write data, held stable until io_ready
//  io_read_data    in   32  sampled on the io_ready cycle of a read
//  io_ready        in   1   1-cycle completion from responder
// BEHAVIOUR
//  Reset: all strobes 0, io_address 0, io_write_data 0, busy/done/pass/timeout 0, err_count 0,
//   first_err_addr 0, state IDLE. Reset mid-transaction abandons it; responder reset by system.
//  Address: addr(i) = (BASE_ADDR & ~3) + 4*i, modulo 2^25 (wraps silently).
//  Pattern: pat(i) = SEED ^ {9'b0, i[22:0]} ^ {i[22:0], 9'b0}; write pass uses pat(i).
//  One outstanding transaction. Strobe pulse exactly 1 cycle; read/write strobe coincide with
//   addr strobe. Next strobe no earlier than cycle after io_ready. io_ready outside
//   *_WAIT ignored.
//  FSM:
//   IDLE    : start -> clear counters/flags, busy=1, done=0, i=0 -> WR_REQ
//   WR_REQ  : addr+write strobe, data pat(i) -> WR_WAIT
//   WR_WAIT : io_ready -> i==NUM_WORDS-1 ? (i=0, RD_REQ) : (i++, WR_REQ)
//   RD_REQ  : addr+read strobe -> RD_WAIT
//   RD_WAIT : io_ready -> compare io_read_data vs pat(i); mismatch: err_count++ (sat),
//              first_err_addr latched if err_count was 0; then last ? DONE : (i++, RD_REQ)
//   DONE    : busy=0, done=1, pass = (err_count==0 && !timeout) -> IDLE same cycle
//  Timeout: counter cleared on each strobe, counts in *_WAIT; reaching TIMEOUT without
//   io_ready -> timeout=1, pass=0, DONE. io_ready arriving same cycle as limit wins.
//  start during busy ignored; start in same cycle done rises ignored; start while done
//   restarts immediately.
//  Min cost per word: 2 cycles + responder latency per access.
// STRUCTURE
//  Shared package: IOM bus width constants (ADDR_W=25, DATA_W=32, BE_W=4), FSM state codes.
//  Sub-module: iom_pattern_gen (combinational pat(i) from SEED, i) reused by future DMA/BIST.
//  Single always block on io_clk for FSM, index, timeout and result registers.
// TESTING (bench uses behavioural IOM responder RAM with programmable ready latency)
//  1 NUM_WORDS=16, latency 1 -> 32 transactions, done, pass=1, err_count=0, RAM[i]=pat(i).
//  2 Responder flips bit0 at word 5 and 9, BASE=0 -> err_count=2, first_err_addr=25'h14, pass=0.
//  3 Latency random 1..40, NUM_WORDS=64 -> strobes 1-cycle, addr/data stable until ready, pass=1.
//  4 Responder never readies word 3, TIMEOUT=16 -> timeout=1, pass=0, done 16 cycles after strobe.
//  5 BASE_ADDR=25'h1FFFFF8, NUM_WORDS=4 -> addresses 1FFFFF8,1FFFFFC,0000000,0000004.
//  6 io_rst asserted in RD_WAIT, then start -> outputs at reset values, fresh test passes.

Source files
------------

// File: rtl/iom_mem_tester_pkg.sv
// Shared IOM bus widths, tester FSM state codes and small helpers.
package iom_mem_tester_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int IDX_W  = 23;
  localparam int ERR_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Word-aligned byte address of word idx; the 25-bit sum wraps silently.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return {base[ADDR_W-1:2], 2'b00} + {idx, 2'b00};
  endfunction

endpackage

// File: rtl/iom_pattern_gen.sv
// Combinational test pattern: SEED folded with the word index at two offsets.
module iom_pattern_gen import iom_mem_tester_pkg::*; #(
  parameter logic [DATA_W-1:0] SEED = 32'hA5A55A5A
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] pat
);

  assign pat = SEED ^ {9'b0, idx} ^ {idx, 9'b0};

endmodule

// File: rtl/iom_mem_tester.sv
// IO bus initiator running a write-then-read-back memory test over a word range.
module iom_mem_tester import iom_mem_tester_pkg::*; #(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 25'h0000000,
  parameter logic [23:0]       NUM_WORDS = 24'd8388608,
  parameter logic [DATA_W-1:0] SEED      = 32'hA5A55A5A,
  parameter logic [15:0]       TIMEOUT   = 16'd1024
) (
  input  logic              io_clk,
  input  logic              io_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              io_addr_strobe,
  output logic              io_read_strobe,
  output logic              io_write_strobe,
  output logic [ADDR_W-1:0] io_address,
  output logic [BE_W-1:0]   io_byte_enable,
  output logic [DATA_W-1:0] io_write_data,
  input  logic [DATA_W-1:0] io_read_data,
  input  logic              io_ready
);

  // Word count clamped to 1..2^23 so the index register never overflows.
  localparam logic [23:0] NW_EFF = (NUM_WORDS == 24'd0)       ? 24'd1 :
                                   (NUM_WORDS > 24'h800000)   ? 24'h800000 : NUM_WORDS;
  localparam logic [23:0] NW_M1  = NW_EFF - 24'd1;
  localparam logic [IDX_W-1:0] LAST_IDX = NW_M1[IDX_W-1:0];
  localparam logic [15:0] TMO_LAST = (TIMEOUT == 16'd0) ? 16'd0 : TIMEOUT - 16'd1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [15:0]        tcnt;
  logic [DATA_W-1:0]  pat;
  logic               is_last;
  logic               mismatch;
  logic [ERR_W-1:0]   err_next;

  iom_pattern_gen #(.SEED(SEED)) u_pat (
    .idx (idx),
    .pat (pat)
  );

  assign io_byte_enable = '1;
  assign is_last        = (idx == LAST_IDX);
  assign mismatch       = (io_read_data != pat);
  assign err_next       = mismatch ? sat_inc(err_count) : err_count;

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state           <= ST_IDLE;
      idx             <= '0;
      tcnt            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      err_count       <= '0;
      first_err_addr  <= '0;
      io_addr_strobe  <= 1'b0;
      io_read_strobe  <= 1'b0;
      io_write_strobe <= 1'b0;
      io_address      <= '0;
      io_write_data   <= '0;
    end else begin
      // Strobes are single-cycle pulses issued only from the *_REQ states.
      io_addr_strobe  <= 1'b0;
      io_read_strobe  <= 1'b0;
      io_write_strobe <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            idx            <= '0;
            state          <= ST_WR_REQ;
          end
        end

        ST_WR_REQ: begin
          io_addr_strobe  <= 1'b1;
          io_write_strobe <= 1'b1;
          io_address      <= word_addr(BASE_ADDR, idx);
          io_write_data   <= pat;
          tcnt            <= '0;
          state           <= ST_WR_WAIT;
        end

        ST_WR_WAIT: begin
          if (io_ready) begin
            if (is_last) begin
              idx   <= '0;
              state <= ST_RD_REQ;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_WR_REQ;
            end
          end else if (tcnt == TMO_LAST) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end

        ST_RD_REQ: begin
          io_addr_strobe <= 1'b1;
          io_read_strobe <= 1'b1;
          io_address     <= word_addr(BASE_ADDR, idx);
          tcnt           <= '0;
          state          <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (io_ready) begin
            err_count <= err_next;
            if (mismatch && (err_count == '0))
              first_err_addr <= io_address;
            if (is_last) begin
              // Result flags land together with the move to DONE so they are visible in it.
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              state <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_RD_REQ;
            end
          end else if (tcnt == TMO_LAST) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end

        // start seen here is deliberately dropped; IDLE accepts the next one.
        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iom_mem_tester.sv
// Four tester instances with different parameters, each against a behavioural IOM RAM responder.
module tb_iom_mem_tester;
  import iom_mem_tester_pkg::*;

  localparam int NI = 4;
  localparam logic [24:0] BASES [NI] = '{25'h0000000, 25'h0000100, 25'h0000000, 25'h1FFFFFB};
  localparam logic [23:0] NWS   [NI] = '{24'd16, 24'd64, 24'd16, 24'd4};
  localparam logic [31:0] SEEDS [NI] = '{32'hA5A55A5A, 32'h12345678, 32'hDEADBEEF, 32'h0F0F00FF};
  localparam logic [15:0] TMOS  [NI] = '{16'd1024, 16'd1024, 16'd16, 16'd1024};

  typedef struct {
    int          k;
    logic [24:0] addr;
    logic        rd;
    logic [31:0] data;
  } txn_t;

  logic        clk;
  logic        rst   [NI];
  logic        start [NI];
  logic        busy [NI], done [NI], pass [NI], timeout [NI];
  logic [15:0] err_count [NI];
  logic [24:0] first_err_addr [NI];
  logic        io_addr_strobe [NI], io_read_strobe [NI], io_write_strobe [NI];
  logic [24:0] io_address [NI];
  logic [3:0]  io_byte_enable [NI];
  logic [31:0] io_write_data [NI];
  logic [31:0] io_read_data [NI] = '{default: 32'h0};
  logic        io_ready [NI] = '{default: 1'b0};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int proto_errs = 0;

  int          lat_min [NI], lat_max [NI], hang_idx [NI];
  bit          flip_en [NI];
  bit          pend [NI] = '{default: 1'b0};
  bit          p_rd [NI];
  logic [24:0] p_addr [NI];
  logic [31:0] p_data [NI];
  int          cnt [NI];
  int          strobe_cyc [NI];
  logic [31:0] mem [bit [26:0]];
  txn_t        log_q [$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    iom_mem_tester #(
      .BASE_ADDR (BASES[g]),
      .NUM_WORDS (NWS[g]),
      .SEED      (SEEDS[g]),
      .TIMEOUT   (TMOS[g])
    ) u_dut (
      .io_clk          (clk),
      .io_rst          (rst[g]),
      .start           (start[g]),
      .busy            (busy[g]),
      .done            (done[g]),
      .pass            (pass[g]),
      .timeout         (timeout[g]),
      .err_count       (err_count[g]),
      .first_err_addr  (first_err_addr[g]),
      .io_addr_strobe  (io_addr_strobe[g]),
      .io_read_strobe  (io_read_strobe[g]),
      .io_write_strobe (io_write_strobe[g]),
      .io_address      (io_address[g]),
      .io_byte_enable  (io_byte_enable[g]),
      .io_write_data   (io_write_data[g]),
      .io_read_data    (io_read_data[g]),
      .io_ready        (io_ready[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [24:0] exp_addr(input int k, input int i);
    longint a;
    a = longint'(BASES[k]) - (longint'(BASES[k]) % 4) + 4 * longint'(i);
    return 25'(a % 33554432);
  endfunction

  function automatic logic [31:0] exp_pat(input int k, input int i);
    return SEEDS[k] ^ 32'(i) ^ 32'(longint'(i) * 512);
  endfunction

  function automatic bit [26:0] key(input int k, input logic [24:0] a);
    return {2'(k), a};
  endfunction

  // Responder: one request at a time, ready 'cnt' cycles after the strobe (cnt 0 = never).
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst[k]) begin
        pend[k]     = 1'b0;
        io_ready[k] = 1'b0;
      end else begin
        io_ready[k] = 1'b0;
        if (io_addr_strobe[k]) begin
          if (pend[k] || (io_read_strobe[k] == io_write_strobe[k]) || (io_byte_enable[k] !== 4'hF))
            proto_errs++;
          pend[k]       = 1'b1;
          p_rd[k]       = io_read_strobe[k];
          p_addr[k]     = io_address[k];
          p_data[k]     = io_write_data[k];
          strobe_cyc[k] = cyc;
          cnt[k]        = $urandom_range(lat_max[k], lat_min[k]);
          if (hang_idx[k] >= 0 && !io_read_strobe[k] && io_address[k] == exp_addr(k, hang_idx[k]))
            cnt[k] = 0;
          log_q.push_back('{k: k, addr: io_address[k], rd: io_read_strobe[k], data: io_write_data[k]});
        end else begin
          if (io_read_strobe[k] || io_write_strobe[k]) proto_errs++;
          if (pend[k]) begin
            if (io_address[k] !== p_addr[k] || (!p_rd[k] && io_write_data[k] !== p_data[k]))
              proto_errs++;
            if (cnt[k] > 0) begin
              cnt[k]--;
              if (cnt[k] == 0) begin
                io_ready[k] = 1'b1;
                pend[k]     = 1'b0;
                if (p_rd[k]) begin
                  io_read_data[k] = mem.exists(key(k, p_addr[k])) ? mem[key(k, p_addr[k])] : 32'h0;
                  if (flip_en[k] && (p_addr[k] == exp_addr(k, 5) || p_addr[k] == exp_addr(k, 9)))
                    io_read_data[k] = io_read_data[k] ^ 32'h1;
                end else begin
                  mem[key(k, p_addr[k])] = p_data[k];
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int k, input string tag);
    chk({tag, "_status"}, {busy[k], done[k], pass[k], timeout[k], err_count[k], first_err_addr[k]}, '0);
    chk({tag, "_bus"}, {io_addr_strobe[k], io_read_strobe[k], io_write_strobe[k], io_address[k], io_write_data[k]}, '0);
    chk({tag, "_be"}, io_byte_enable[k], 4'hF);
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk) start[k] = 1'b1;
    @(negedge clk) start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, input string tag, output int at);
    at = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done[k] === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk({tag, "_done_reached"}, 1'b0, 1'b1);
  endtask

  task automatic check_run(input int k, input int n, input string tag);
    int seen, bad;
    int i;
    seen = 0;
    bad  = 0;
    foreach (log_q[j]) begin
      if (log_q[j].k == k) begin
        if (seen < 2 * n) begin
          i = seen % n;
          if (log_q[j].addr !== exp_addr(k, i) || log_q[j].rd !== (seen >= n) ||
              (seen < n && log_q[j].data !== exp_pat(k, i)))
            bad++;
        end
        seen++;
      end
    end
    chk({tag, "_txn_count"}, seen, 2 * n);
    chk({tag, "_txn_seq"}, bad, 0);
    bad = 0;
    for (int w = 0; w < n; w++)
      if (!mem.exists(key(k, exp_addr(k, w))) || mem[key(k, exp_addr(k, w))] !== exp_pat(k, w)) bad++;
    chk({tag, "_ram"}, bad, 0);
  endtask

  initial begin
    int at;
    int seen;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0;
      lat_min[k] = 1; lat_max[k] = 1; hang_idx[k] = -1; flip_en[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk_reset(k, $sformatf("reset%0d", k));

    // Basic run, latency 1
    log_q.delete();
    pulse_start(0);
    chk("t1_busy_done", {busy[0], done[0]}, 2'b10);
    wait_done(0, 1000, "t1", at);
    chk("t1_result", {pass[0], timeout[0], busy[0], err_count[0], first_err_addr[0]}, {3'b100, 16'd0, 25'd0});
    check_run(0, 16, "t1");

    // Restart from done with corrupted reads at words 5 and 9
    flip_en[0] = 1'b1;
    log_q.delete();
    pulse_start(0);
    chk("t2_restart", {busy[0], done[0]}, 2'b10);
    wait_done(0, 1000, "t2", at);
    chk("t2_err_count", err_count[0], 16'd2);
    chk("t2_first_err", first_err_addr[0], 25'h14);
    chk("t2_pass_tmo", {pass[0], timeout[0]}, 2'b00);
    flip_en[0] = 1'b0;

    // Rerun clean: previous errors must be cleared
    pulse_start(0);
    wait_done(0, 1000, "t2b", at);
    chk("t2b_result", {pass[0], err_count[0], first_err_addr[0]}, {1'b1, 16'd0, 25'd0});

    // Random latency, plus a start while busy that must be ignored
    lat_min[1] = 1; lat_max[1] = 40;
    proto_errs = 0;
    log_q.delete();
    pulse_start(1);
    repeat (50) @(negedge clk);
    pulse_start(1);
    wait_done(1, 12000, "t3", at);
    chk("t3_pass", {pass[1], timeout[1], err_count[1]}, {2'b10, 16'd0});
    check_run(1, 64, "t3");
    chk("t3_protocol", proto_errs, 0);

    // Responder never readies word 3 of the write pass
    hang_idx[2] = 3;
    log_q.delete();
    pulse_start(2);
    wait_done(2, 500, "t4", at);
    chk("t4_done_latency", at - strobe_cyc[2], 16);
    chk("t4_flags", {timeout[2], pass[2], busy[2]}, 3'b100);
    chk("t4_txn_count", log_q.size(), 4);

    // Address wrap at the top of the 25-bit space; low base bits ignored
    log_q.delete();
    pulse_start(3);
    wait_done(3, 500, "t5", at);
    chk("t5_pass", pass[3], 1'b1);
    chk("t5_addr0", log_q.size() > 0 ? log_q[0].addr : 25'h0AAAAAA, 25'h1FFFFF8);
    chk("t5_addr1", log_q.size() > 1 ? log_q[1].addr : 25'h0AAAAAA, 25'h1FFFFFC);
    chk("t5_addr2", log_q.size() > 2 ? log_q[2].addr : 25'h0AAAAAA, 25'h0000000);
    chk("t5_addr3", log_q.size() > 3 ? log_q[3].addr : 25'h0AAAAAA, 25'h0000004);
    check_run(3, 4, "t5");

    // Reset while a read is outstanding, then a fresh test
    lat_min[0] = 6; lat_max[0] = 6;
    log_q.delete();
    pulse_start(0);
    seen = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (pend[0] && p_rd[0]) begin
        seen = 1;
        break;
      end
    end
    chk("t6_read_reached", seen, 1);
    @(negedge clk);
    rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    chk_reset(0, "t6_after_rst");
    lat_min[0] = 1; lat_max[0] = 1;
    log_q.delete();
    pulse_start(0);
    wait_done(0, 1000, "t6", at);
    chk("t6_pass", {pass[0], timeout[0], err_count[0]}, {2'b10, 16'd0});
    check_run(0, 16, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
